// File: rtl/mb20_read_sequencer_if.sv
// Bundle of requester-side and MB20 MBUS-side signals around mb20_read_sequencer.
// parErr exists only when MB20_SEQ_PARITY_CHECK_EN is defined.
interface mb20_read_sequencer_if #(
  parameter int ADR_W = 22
);
  logic [1:0]       req;
  logic [ADR_W-1:0] reqAdr0;
  logic [ADR_W-1:0] reqAdr1;
  logic [0:3]       reqRq0;
  logic [0:3]       reqRq1;

  logic [1:0]       grant;
  logic [35:0]      wordOut;
  logic [1:0]       wordIdx;
  logic             wordValid;
  logic             done;
  logic             nxm;

  logic             memStart;
  logic             memRdRq;
  logic [0:3]       memRq;
  logic [ADR_W-1:0] memAdr;
  logic             memAdrHold;
  logic             memAckn;
  logic             memValid;
  logic [35:0]      memD;
  logic             memPar;

`ifdef MB20_SEQ_PARITY_CHECK_EN
  logic             parErr;
`endif

  // Sequencer side: consumes requests and memory responses, drives grant/data/MBUS.
  modport master (
`ifdef MB20_SEQ_PARITY_CHECK_EN
    output parErr,
`endif
    input  req, reqAdr0, reqAdr1, reqRq0, reqRq1,
           memAckn, memValid, memD, memPar,
    output grant, wordOut, wordIdx, wordValid, done, nxm,
           memStart, memRdRq, memRq, memAdr, memAdrHold
  );

  modport slave (
`ifdef MB20_SEQ_PARITY_CHECK_EN
    input  parErr,
`endif
    output req, reqAdr0, reqAdr1, reqRq0, reqRq1,
           memAckn, memValid, memD, memPar,
    input  grant, wordOut, wordIdx, wordValid, done, nxm,
           memStart, memRdRq, memRq, memAdr, memAdrHold
  );
endinterface

// File: rtl/mb20_read_sequencer.sv
// Shares one MB20 MBUS read phase between two requesters: round-robin grant, START/RQ/ADR
// sequencing, edge-detected word capture and ACKN timeout (NXM).
// Optional MB20_SEQ_PARITY_CHECK_EN adds an odd-parity error strobe (parErr).
module mb20_read_sequencer #(
  parameter int ACK_TIMEOUT = 64,
  parameter int ADR_W       = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  mb20_read_sequencer_if.master io_bus
);

  localparam int               TMR_W    = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_XFER
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [1:0]       r_grant;
  logic             r_prio;
  logic [ADR_W-1:0] r_adr;
  logic [0:3]       r_mask;
  logic [2:0]       r_expect;
  logic [2:0]       r_captured;
  logic [TMR_W-1:0] r_timer;
  logic             r_validQ;
  logic [35:0]      r_wordOut;
  logic [1:0]       r_wordIdx;
  logic             r_wordValid;
  logic             r_done;
  logic             r_nxm;

  logic             w_pick;
  logic [ADR_W-1:0] w_pickAdr;
  logic [0:3]       w_pickMask;
  logic [1:0]       w_pickGrant;
  logic             w_grantNow;
  logic             w_capture;
  logic             w_timeout;
  logic             w_finished;
  logic [1:0]       w_captureIdx;

  function automatic logic [2:0] countBits(input logic [0:3] mask);
    logic [2:0] n;
    n = '0;
    for (int j = 0; j < 4; j++) begin
      n = n + {2'b00, mask[j]};
    end
    return n;
  endfunction

  // Offset from the starting word of the k-th set mask bit (mask bit j = start word + j).
  function automatic logic [1:0] slotOf(input logic [0:3] mask, input logic [2:0] k);
    logic [2:0] seen;
    logic [1:0] pos;
    seen = '0;
    pos  = '0;
    for (int j = 0; j < 4; j++) begin
      if (mask[j]) begin
        if (seen == k) pos = 2'(j);
        seen = seen + 3'd1;
      end
    end
    return pos;
  endfunction

  always_comb begin
    w_pick = 1'b0;
    if (io_bus.req == 2'b11) w_pick = r_prio;
    else                     w_pick = io_bus.req[1];
    w_pickAdr   = w_pick ? io_bus.reqAdr1 : io_bus.reqAdr0;
    w_pickMask  = w_pick ? io_bus.reqRq1  : io_bus.reqRq0;
    w_pickGrant = w_pick ? 2'b10 : 2'b01;
  end

  // r_done blocks a re-grant so consecutive cycles always see one idle clock between them.
  assign w_grantNow   = (r_state == S_IDLE) && !r_done && (io_bus.req != 2'b00);
  assign w_capture    = (r_state != S_IDLE) && io_bus.memValid && !r_validQ &&
                        (r_captured != r_expect);
  assign w_timeout    = (r_state != S_IDLE) && (r_timer == TMR_LAST) &&
                        !w_capture && !io_bus.memAckn;
  assign w_finished   = (r_state == S_XFER) && (r_captured == r_expect);
  assign w_captureIdx = r_adr[1:0] + slotOf(r_mask, r_captured);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grantNow && (w_pickMask != 4'b0000)) w_nextState = S_START;
      end
      S_START: begin
        if (w_timeout)               w_nextState = S_IDLE;
        else if (io_bus.memAckn)     w_nextState = S_XFER;
      end
      S_XFER: begin
        if (w_finished || w_timeout) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    io_bus.memStart   = 1'b0;
    io_bus.memAdrHold = 1'b0;
    io_bus.memRdRq    = 1'b0;
    io_bus.memRq      = 4'b0000;
    io_bus.memAdr     = '0;
    if (r_state == S_START) begin
      io_bus.memStart   = 1'b1;
      io_bus.memAdrHold = 1'b1;
    end
    if (r_state != S_IDLE) begin
      io_bus.memRdRq = 1'b1;
      io_bus.memRq   = r_mask;
      io_bus.memAdr  = r_adr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant     <= 2'b00;
      r_prio      <= 1'b0;
      r_adr       <= '0;
      r_mask      <= 4'b0000;
      r_expect    <= '0;
      r_captured  <= '0;
      r_timer     <= '0;
      r_validQ    <= 1'b0;
      r_wordOut   <= '0;
      r_wordIdx   <= '0;
      r_wordValid <= 1'b0;
      r_done      <= 1'b0;
      r_nxm       <= 1'b0;
    end else begin
      r_validQ    <= io_bus.memValid;
      r_wordValid <= w_capture;
      r_done      <= 1'b0;
      r_nxm       <= 1'b0;
      if (w_capture) begin
        r_wordOut  <= io_bus.memD;
        r_wordIdx  <= w_captureIdx;
        r_captured <= r_captured + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grantNow) begin
            r_grant    <= w_pickGrant;
            r_prio     <= ~w_pick;
            r_adr      <= w_pickAdr;
            r_mask     <= w_pickMask;
            r_expect   <= countBits(w_pickMask);
            r_captured <= '0;
            r_timer    <= '0;
            if (w_pickMask == 4'b0000) r_done <= 1'b1;
          end else begin
            r_grant <= 2'b00;
          end
        end
        S_START, S_XFER: begin
          if (io_bus.memAckn || w_capture) r_timer <= '0;
          else                             r_timer <= r_timer + TMR_W'(1);
          if (w_finished || w_timeout) begin
            r_done  <= 1'b1;
            r_nxm   <= !w_finished;
            r_grant <= 2'b00;
          end
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

`ifdef MB20_SEQ_PARITY_CHECK_EN
  logic r_parErr;

  // Odd parity: memPar should equal the inverted XOR of the data word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_parErr <= 1'b0;
    else       r_parErr <= w_capture && (io_bus.memPar != ~^io_bus.memD);
  end

  assign io_bus.parErr = r_parErr;
`endif

  assign io_bus.grant     = r_grant;
  assign io_bus.wordOut   = r_wordOut;
  assign io_bus.wordIdx   = r_wordIdx;
  assign io_bus.wordValid = r_wordValid;
  assign io_bus.done      = r_done;
  assign io_bus.nxm       = r_nxm;

endmodule

// File: tb/tb_mb20_read_sequencer.sv
// Directed bench for mb20_read_sequencer: a vector table of single read cycles plus
// hand-written reset-mid-transfer and round-robin sequences; ACK_TIMEOUT shortened to 8.
module tb_mb20_read_sequencer;

  localparam int ADR_W       = 22;
  localparam int ACK_TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  int   nCompared   = 0;
  int   nMismatched = 0;

  mb20_read_sequencer_if #(.ADR_W(ADR_W)) bus ();

  mb20_read_sequencer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .ADR_W      (ADR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // One read cycle; memory ACKNs word k at cycle 3+4k and holds DATA VALID on 4+4k, 5+4k.
  typedef struct {
    logic [1:0]       req;
    logic [ADR_W-1:0] adr;
    logic [0:3]       rq;
    logic             ackEn;
    int               nWords;
    logic [3:0][35:0] words;
    logic [3:0][1:0]  idx;
    logic [1:0]       expGrant;
    logic             expNxm;
    int               expDoneC;
    int               expStartCnt;
    int               badPar;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idleInputs();
    bus.req      = 2'b00;
    bus.reqAdr0  = '0;
    bus.reqAdr1  = '0;
    bus.reqRq0   = 4'b0000;
    bus.reqRq1   = 4'b0000;
    bus.memAckn  = 1'b0;
    bus.memValid = 1'b0;
    bus.memD     = '0;
    bus.memPar   = 1'b1;
  endtask

  task automatic setVec(input int i, input logic [1:0] req, input logic [ADR_W-1:0] adr,
                        input logic [0:3] rq, input logic ackEn, input int nWords,
                        input logic [35:0] w0, input logic [35:0] w1,
                        input logic [35:0] w2, input logic [35:0] w3,
                        input logic [1:0] i0, input logic [1:0] i1,
                        input logic [1:0] i2, input logic [1:0] i3,
                        input logic [1:0] expGrant, input logic expNxm, input int expDoneC,
                        input int expStartCnt, input int badPar);
    vecs[i].req         = req;
    vecs[i].adr         = adr;
    vecs[i].rq          = rq;
    vecs[i].ackEn       = ackEn;
    vecs[i].nWords      = nWords;
    vecs[i].words       = {w3, w2, w1, w0};
    vecs[i].idx         = {i3, i2, i1, i0};
    vecs[i].expGrant    = expGrant;
    vecs[i].expNxm      = expNxm;
    vecs[i].expDoneC    = expDoneC;
    vecs[i].expStartCnt = expStartCnt;
    vecs[i].badPar      = badPar;
  endtask

  task automatic applyStimulus(input int vi);
    vec_t             v;
    int               gotWords, doneCnt, doneC, startCnt, nxmCnt, parCnt, parWord;
    logic [1:0]       gotGrant;
    logic [3:0][35:0] gotData;
    logic [3:0][1:0]  gotIdx;
    logic [ADR_W-1:0] seenAdr;
    logic [0:3]       seenRq;
    v        = vecs[vi];
    gotWords = 0; doneCnt = 0; doneC = -1; startCnt = 0; nxmCnt = 0; parCnt = 0; parWord = -1;
    gotGrant = 2'b00; gotData = '0; gotIdx = '0; seenAdr = '0; seenRq = 4'b0000;
    bus.reqAdr0 = v.adr; bus.reqAdr1 = v.adr;
    bus.reqRq0  = v.rq;  bus.reqRq1  = v.rq;
    bus.req     = v.req;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.grant != 2'b00 && gotGrant == 2'b00) gotGrant = bus.grant;
      if (c == 1) begin
        seenAdr = bus.memAdr;
        seenRq  = bus.memRq;
      end
      if (bus.memStart) startCnt++;
      if (bus.nxm) nxmCnt++;
`ifdef MB20_SEQ_PARITY_CHECK_EN
      if (bus.parErr) begin
        parCnt++;
        parWord = bus.wordValid ? gotWords : -2;
      end
`endif
      if (bus.wordValid) begin
        if (gotWords < 4) begin
          gotData[gotWords] = bus.wordOut;
          gotIdx[gotWords]  = bus.wordIdx;
        end
        gotWords++;
      end
      if (bus.done) begin
        doneCnt++;
        if (doneC < 0) doneC = c;
        bus.req = 2'b00;
      end
      bus.memAckn  = 1'b0;
      bus.memValid = 1'b0;
      if (v.ackEn) begin
        for (int k = 0; k < v.nWords; k++) begin
          if (c == 3 + 4 * k) bus.memAckn = 1'b1;
          if (c == 4 + 4 * k || c == 5 + 4 * k) begin
            bus.memValid = 1'b1;
            bus.memD     = v.words[k];
            bus.memPar   = ~^v.words[k];
            if (k == v.badPar) bus.memPar = ~bus.memPar;
          end
        end
      end
    end
    checkOutput($sformatf("v%0d grant", vi), gotGrant, v.expGrant);
    checkOutput($sformatf("v%0d wordCount", vi), gotWords, v.nWords);
    for (int k = 0; k < v.nWords; k++) begin
      checkOutput($sformatf("v%0d word%0d data", vi, k), gotData[k], v.words[k]);
      checkOutput($sformatf("v%0d word%0d idx", vi, k), gotIdx[k], v.idx[k]);
    end
    checkOutput($sformatf("v%0d doneCount", vi), doneCnt, 1);
    checkOutput($sformatf("v%0d doneCycle", vi), doneC, v.expDoneC);
    checkOutput($sformatf("v%0d nxmCount", vi), nxmCnt, v.expNxm ? 1 : 0);
    checkOutput($sformatf("v%0d startCycles", vi), startCnt, v.expStartCnt);
    if (v.expStartCnt > 0) begin
      checkOutput($sformatf("v%0d memAdr", vi), seenAdr, v.adr);
      checkOutput($sformatf("v%0d memRq", vi), seenRq, v.rq);
    end
`ifdef MB20_SEQ_PARITY_CHECK_EN
    checkOutput($sformatf("v%0d parErrCount", vi), parCnt, (v.badPar >= 0) ? 1 : 0);
    if (v.badPar >= 0) checkOutput($sformatf("v%0d parErrWord", vi), parWord, v.badPar);
`endif
  endtask

  task automatic resetMidXfer();
    bus.reqAdr0 = '0;
    bus.reqRq0  = 4'b1111;
    bus.req     = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.memAckn  = (c == 3);
      bus.memValid = (c == 4 || c == 5);
      bus.memD     = 36'o111;
      bus.memPar   = ~^bus.memD;
    end
    checkOutput("xfer before reset {memStart,memRdRq}", {bus.memStart, bus.memRdRq}, 2'b01);
    checkOutput("xfer before reset wordOut", bus.wordOut, 36'o111);
    reset = 1'b1;
    #1;
    checkOutput("mid-xfer reset controls",
                {bus.grant, bus.wordValid, bus.done, bus.nxm, bus.memStart,
                 bus.memRdRq, bus.memRq, bus.memAdrHold, bus.wordIdx}, '0);
    checkOutput("mid-xfer reset memAdr", bus.memAdr, '0);
    checkOutput("mid-xfer reset wordOut", bus.wordOut, '0);
    idleInputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic arbitrationSequence();
    int               nGrant, doneCnt, wvCnt, overlap, lastDoneC, minGap, cp;
    logic             active, firstStart;
    logic [1:0]       prevGrant;
    logic [2:0][1:0]  grants;
    nGrant = 0; doneCnt = 0; wvCnt = 0; overlap = 0; lastDoneC = -100; minGap = 1000; cp = 0;
    active = 1'b0; firstStart = 1'b0; prevGrant = 2'b00; grants = '0;
    bus.reqAdr0 = '0;
    bus.reqAdr1 = 22'o5;
    bus.reqRq0  = 4'b1000;
    bus.reqRq1  = 4'b1000;
    bus.req     = 2'b11;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.grant == 2'b11) overlap++;
      if (bus.grant != 2'b00 && prevGrant == 2'b00) begin
        if (nGrant < 3) grants[nGrant] = bus.grant;
        if (nGrant == 0) firstStart = bus.memStart;
        nGrant++;
        if (c - lastDoneC < minGap) minGap = c - lastDoneC;
      end
      prevGrant = bus.grant;
      if (bus.wordValid) wvCnt++;
      if (bus.done) begin
        doneCnt++;
        lastDoneC = c;
        if (doneCnt == 3) bus.req = 2'b00;
      end
      if (active) cp++;
      if (active && cp > 6) active = 1'b0;
      if (!active && bus.memStart) begin
        active = 1'b1;
        cp     = 0;
      end
      bus.memAckn  = active && (cp == 2);
      bus.memValid = active && (cp == 3 || cp == 4);
      bus.memD     = 36'o1234;
      bus.memPar   = ~^bus.memD;
    end
    checkOutput("arb first grant starts at START", firstStart, 1'b1);
    checkOutput("arb grant count", nGrant, 3);
    checkOutput("arb grant 0", grants[0], 2'b01);
    checkOutput("arb grant 1", grants[1], 2'b10);
    checkOutput("arb grant 2", grants[2], 2'b01);
    checkOutput("arb overlap", overlap, 0);
    checkOutput("arb done count", doneCnt, 3);
    checkOutput("arb wordValid count", wvCnt, 3);
    checkOutput("arb idle gap >= 2", (minGap >= 2) ? 1 : 0, 1);
  endtask

  initial begin
    setVec(0, 2'b01, 22'o1000,   4'b1111, 1'b1, 4, 36'o1, 36'o2, 36'o3, 36'o4,
           2'd0, 2'd1, 2'd2, 2'd3, 2'b01, 1'b0, 18, 3, -1);
    setVec(1, 2'b01, 22'o1003,   4'b1010, 1'b1, 2, 36'o777777777777, 36'o525252525252, 36'o0, 36'o0,
           2'd3, 2'd1, 2'd0, 2'd0, 2'b01, 1'b0, 10, 3, -1);
    setVec(2, 2'b10, 22'o2000,   4'b0000, 1'b1, 0, 36'o0, 36'o0, 36'o0, 36'o0,
           2'd0, 2'd0, 2'd0, 2'd0, 2'b10, 1'b0, 1, 0, -1);
    setVec(3, 2'b01, 22'o3000,   4'b1100, 1'b0, 0, 36'o0, 36'o0, 36'o0, 36'o0,
           2'd0, 2'd0, 2'd0, 2'd0, 2'b01, 1'b1, 9, 8, -1);
    setVec(4, 2'b10, 22'o777776, 4'b0111, 1'b1, 3, 36'o10, 36'o20, 36'o30, 36'o0,
           2'd3, 2'd0, 2'd1, 2'd0, 2'b10, 1'b0, 14, 3, -1);
    setVec(5, 2'b01, 22'o4000,   4'b1111, 1'b1, 4, 36'o123, 36'o456, 36'o701, 36'o11,
           2'd0, 2'd1, 2'd2, 2'd3, 2'b01, 1'b0, 18, 3, 1);

    reset = 1'b1;
    idleInputs();
    repeat (2) @(negedge clk);
    checkOutput("reset controls",
                {bus.grant, bus.wordValid, bus.done, bus.nxm, bus.memStart,
                 bus.memRdRq, bus.memRq, bus.memAdrHold, bus.wordIdx}, '0);
    checkOutput("reset memAdr", bus.memAdr, '0);
    checkOutput("reset wordOut", bus.wordOut, '0);
    reset = 1'b0;

    for (int vi = 0; vi < 6; vi++) applyStimulus(vi);

    resetMidXfer();
    arbitrationSequence();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
